// File: rtl/fetch_stage_pkg.sv
// Shared pipeline constants, fetch FSM state encoding and the IF/ID payload type.
// Imported by the fetch stage and its IF/ID register.
package fetch_stage_pkg;

    localparam logic [15:0] NOP      = 16'h0800;
    localparam logic [4:0]  HALT_OP  = 5'b00000;
    localparam logic [15:0] RESET_PC = 16'h0000;

    localparam logic [1:0] ST_REQ    = 2'd0;
    localparam logic [1:0] ST_DROP   = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    typedef struct packed {
        logic        halt;
        logic [15:0] instr;
        logic [15:0] pc;
        logic [15:0] pc2;
    } ifid_t;

    localparam ifid_t IFID_NOP = '{halt: 1'b0, instr: NOP, pc: 16'h0000, pc2: 16'h0000};

    function automatic logic is_halt(input logic [15:0] word);
        return word[15:11] == HALT_OP;
    endfunction

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register: 49-bit payload, one-cycle latency.
// nop_load overrides en; en low holds the current contents (stall).
module ifid_reg
    import fetch_stage_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  en,
    input  logic  nop_load,
    input  ifid_t d,
    output ifid_t q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= IFID_NOP;
        end else if (nop_load) begin
            q <= IFID_NOP;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: one outstanding imem request, redirects, stall buffering and HALT detection.
// IF/ID updates one edge after imem_done; stall freezes IF/ID and parks at most one returned word.
module fetch_stage
    import fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stallCtrl,
    input  logic        takeBranch_EXMEM,
    input  logic [15:0] branchTarget,
    input  logic        jumpFlush,
    input  logic [15:0] jumpTarget,
    output logic        imem_rd,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    input  logic        imem_done,
    output logic [15:0] instr_IFID,
    output logic [15:0] PC_IFID,
    output logic [15:0] PC2_IFID,
    output logic        halt_IFID
);

    logic [1:0]  state, state_nxt;
    logic [15:0] pc, pc_nxt;
    logic [15:0] req_addr, req_addr_nxt;
    logic [15:0] buf_data, buf_data_nxt;
    logic        buf_valid, buf_valid_nxt;

    logic        redirect;
    logic [15:0] redirect_target;
    logic        fetch_pending;
    logic [15:0] seq_addr;
    logic [15:0] fetch_word;

    logic        ifid_en;
    logic        ifid_nop;
    ifid_t       ifid_d;
    ifid_t       ifid_q;

    assign redirect        = takeBranch_EXMEM | jumpFlush;
    assign redirect_target = takeBranch_EXMEM ? branchTarget : jumpTarget;
    assign seq_addr        = req_addr + 16'd2;
    assign fetch_word      = buf_valid ? buf_data : imem_data;

    // A request is on the bus in REQ (unless a word is parked) and while draining a dropped one.
    assign fetch_pending = ((state == ST_REQ) && !buf_valid) || (state == ST_DROP);
    assign imem_rd       = rst & fetch_pending;
    assign imem_addr     = req_addr;

    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        req_addr_nxt  = req_addr;
        buf_valid_nxt = buf_valid;
        buf_data_nxt  = buf_data;
        ifid_en       = 1'b0;
        ifid_nop      = 1'b0;
        ifid_d.halt   = is_halt(fetch_word);
        ifid_d.instr  = fetch_word;
        ifid_d.pc     = req_addr;
        ifid_d.pc2    = seq_addr;

        if (redirect) begin
            ifid_nop      = 1'b1;
            pc_nxt        = redirect_target;
            buf_valid_nxt = 1'b0;
            // An unanswered request must still complete on the bus before the new address goes out.
            if (fetch_pending && !imem_done) begin
                state_nxt = ST_DROP;
            end else begin
                req_addr_nxt = redirect_target;
                state_nxt    = ST_REQ;
            end
        end else begin
            case (state)
                ST_REQ: begin
                    if (stallCtrl) begin
                        if (imem_done && !buf_valid) begin
                            buf_valid_nxt = 1'b1;
                            buf_data_nxt  = imem_data;
                        end
                    end else if (buf_valid || imem_done) begin
                        ifid_en       = 1'b1;
                        buf_valid_nxt = 1'b0;
                        pc_nxt        = seq_addr;
                        req_addr_nxt  = seq_addr;
                        if (is_halt(fetch_word)) begin
                            state_nxt = ST_HALTED;
                        end
                    end else begin
                        ifid_nop = 1'b1;
                    end
                end
                ST_DROP: begin
                    ifid_nop = !stallCtrl;
                    if (imem_done) begin
                        req_addr_nxt = pc;
                        state_nxt    = ST_REQ;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_REQ;
            pc        <= RESET_PC;
            req_addr  <= RESET_PC;
            buf_valid <= 1'b0;
            buf_data  <= 16'h0000;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            req_addr  <= req_addr_nxt;
            buf_valid <= buf_valid_nxt;
            buf_data  <= buf_data_nxt;
        end
    end

    ifid_reg u_ifid_reg (
        .clk      (clk),
        .rst      (rst),
        .en       (ifid_en),
        .nop_load (ifid_nop),
        .d        (ifid_d),
        .q        (ifid_q)
    );

    assign instr_IFID = ifid_q.instr;
    assign PC_IFID    = ifid_q.pc;
    assign PC2_IFID   = ifid_q.pc2;
    assign halt_IFID  = ifid_q.halt;

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have ports: clk  in  1  single rising-edge clock.
REQ-002 SHALL have: rst  in  1  asynchronous, active-low reset.
REQ-003 SHALL have: stallCtrl  in  1  hold request from the hazard unit.
REQ-004 SHALL have: takeBranch_EXMEM  in  1  branch redirect; branchTarget  in  16  branch destination.
REQ-005 SHALL have: jumpFlush  in  1  jump redirect; jumpTarget  in  16  jump destination.
REQ-006 SHALL have: imem_rd  out  1  read request; imem_addr  out  16  request address.
REQ-007 SHALL have: imem_data  in  16  instruction word; imem_done  in  1  data valid this cycle.
REQ-008 SHALL have: instr_IFID  out  16; PC_IFID  out  16; PC2_IFID  out  16; halt_IFID  out  1 (IF/ID register outputs).
REQ-009 SHALL have constants: NOP = 16'h0800; HALT opcode = instr[15:11] == 5'b00000; RESET_PC = 16'h0000.

Function
REQ-010 PC SHALL be 16 bits; PC2 = PC + 2, modulo 2^16 (16'hFFFE + 2 = 16'h0000).
REQ-011 States SHALL be: REQ, DROP, HALTED.
REQ-012 In REQ, imem_rd = 1 and imem_addr = the latched request address (reqAddr), held stable until imem_done.
REQ-013 REQ with imem_done, no redirect, no stall: on the next edge, IF/ID = {imem_data, reqAddr, reqAddr+2}, PC and reqAddr advance to reqAddr+2.
REQ-014 REQ without imem_done: IF/ID SHALL load NOP with halt_IFID = 0 (bubble), and PC SHALL hold.
REQ-015 Redirect SHALL mean takeBranch_EXMEM | jumpFlush; on a same-cycle conflict, branchTarget SHALL win over jumpTarget.
REQ-016 Redirect SHALL outrank stall and SHALL load NOP into IF/ID on the next edge, in every state.
REQ-017 Redirect in REQ with imem_done (or in HALTED) SHALL load PC and reqAddr with the target and enter or stay in REQ.
REQ-018 Redirect in REQ without imem_done SHALL load PC with the target and enter DROP; reqAddr and imem_rd SHALL be held.
REQ-019 In DROP, imem_rd SHALL stay high on the old reqAddr until imem_done; the returned data is discarded, reqAddr is set to PC, and the state returns to REQ.
REQ-020 A further redirect while in DROP SHALL update PC only.
REQ-021 stallCtrl without redirect SHALL hold the IF/ID register and PC unchanged.
REQ-022 imem_done arriving during a stall SHALL be captured in a one-entry buffer (bufValid, bufData); imem_rd SHALL deassert while bufValid = 1.
REQ-023 On stall release with bufValid = 1, IF/ID SHALL load bufData without a new memory request, and bufValid SHALL clear.
REQ-024 A redirect SHALL clear bufValid.
REQ-025 Loading an instruction with HALT opcode SHALL set halt_IFID = 1 and enter HALTED.
REQ-026 In HALTED, imem_rd = 0, IF/ID SHALL hold, and PC SHALL hold; only a redirect or reset exits HALTED.

Reset
REQ-027 Reset SHALL act asynchronously on the rst falling edge and release synchronously.
REQ-028 While reset is asserted: PC = reqAddr = 16'h0000, state = REQ, bufValid = 0, instr_IFID = NOP, PC_IFID = PC2_IFID = 0, halt_IFID = 0, imem_rd = 0.
REQ-029 The first request SHALL be issued in the first cycle after reset release.
REQ-030 Reset asserted mid-request or in DROP SHALL abandon the transaction with no pending-state memory.

Structure
REQ-031 NOP, the HALT opcode, RESET_PC, and the state encoding SHALL live in the shared pipeline package.
REQ-032 The IF/ID register SHALL be one sub-module, ifid_reg: 49 bits, enable plus synchronous NOP-load, with async active-low reset.
REQ-033 The next-PC selection and the FSM SHALL reside in fetch_stage.

Verification
REQ-034 Zero-wait memory returning 0x4001, 0x4002 at addresses 0, 2 -> IF/ID shows (0x4001, 0, 2), then (0x4002, 2, 4) on consecutive cycles.
REQ-035 Memory waiting 2 cycles on addr 0x0010 -> two NOP bubbles, imem_addr stable at 0x0010, then the instruction is loaded.
REQ-036 takeBranch_EXMEM = 1 with target 0x0100 while the request at 0x0020 is pending -> DROP, 0x0020 data discarded, next imem_addr = 0x0100, IF/ID = NOP.
REQ-037 jumpFlush and takeBranch_EXMEM in the same cycle (targets 0x0200 / 0x0300) -> PC = 0x0300.
REQ-038 stallCtrl high for 3 cycles while imem_done occurs -> IF/ID frozen, imem_rd low after capture, buffered word loaded on release with no refetch.
REQ-039 Fetch 0x0000 at PC 0x0008 -> halt_IFID = 1, imem_rd = 0 thereafter; then a branch to 0x0040 -> halt_IFID = 0, fetch resumes at 0x0040; rst pulse low mid-wait -> all REQ-028 values immediately.
